// File: rtl/tb_mem_arbiter.sv
// Two-port (instruction fetch / data LSU) to single-port RAM arbiter with 1-cycle response path.
// Optional grant/conflict statistics counters when ARB_STATS_EN is defined.
module tb_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_i_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_conflicts
`endif
);

    localparam bit FIXED = (PRIO_MODE == 1);

    logic       last_d;
    logic [1:0] vld_pipe;

    // On conflict D wins under fixed priority, otherwise whoever did not own the last grant.
    always_comb begin
        d_gnt = d_req & ~(i_req & ~FIXED & last_d);
        i_gnt = i_req & ~d_gnt;
    end

    assign mem_we   = d_gnt & d_we;
    assign mem_addr = d_gnt ? d_addr : i_addr;
    assign mem_din  = d_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d   <= 1'b1;
            vld_pipe <= 2'b00;
        end else begin
            vld_pipe <= {d_gnt, i_gnt};
            if (i_gnt | d_gnt)
                last_d <= d_gnt;
        end
    end

    assign i_rvalid = vld_pipe[0];
    assign d_rvalid = vld_pipe[1];
    assign i_rdata  = mem_dout;
    assign d_rdata  = mem_dout;

`ifdef ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_i_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (i_gnt)         stat_i_grants  <= sat_inc(stat_i_grants);
            if (d_gnt)         stat_d_grants  <= sat_inc(stat_d_grants);
            if (i_req & d_req) stat_conflicts <= sat_inc(stat_conflicts);
        end
    end
`endif

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Bench for tb_mem_arbiter: round-robin and fixed-priority instances side by side, each with its
// own read-first RAM, checked every cycle against a word-level model of grants, data and stats.
module tb_tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       i_req, d_req, d_we;
    logic [1:0][31:0] i_addr, d_addr, d_wdata;

    logic [1:0]       o_i_gnt, o_i_rvalid, o_d_gnt, o_d_rvalid, o_mem_we;
    logic [1:0][31:0] o_i_rdata, o_d_rdata, o_mem_addr, o_mem_din;
`ifdef ARB_STATS_EN
    logic [1:0][31:0] o_st_i, o_st_d, o_st_c;
`endif

    function automatic logic [31:0] ram_init(input int k);
        return 32'hC0DE_0000 ^ (k * 32'h0101_0101);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_m
        logic        gi, gd, rvi, rvd, we;
        logic [31:0] rdi, rdd, ma, md, dout;
        logic [31:0] ram [256];
`ifdef ARB_STATS_EN
        logic [31:0] si, sd, sc;
`endif
        tb_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(g)) u_dut (
            .clk(clk), .rst(rst),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_gnt(gi), .i_rvalid(rvi), .i_rdata(rdi),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_gnt(gd), .d_rvalid(rvd), .d_rdata(rdd),
            .mem_we(we), .mem_addr(ma), .mem_din(md), .mem_dout(dout)
`ifdef ARB_STATS_EN
            , .stat_i_grants(si), .stat_d_grants(sd), .stat_conflicts(sc)
`endif
        );

        // Read-first RAM; reloaded with its known pattern whenever rst is high.
        always @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < 256; k++) ram[k] <= ram_init(k);
            end else if (we) begin
                ram[ma[9:2]] <= md;
            end
            dout <= ram[ma[9:2]];
        end

        assign o_i_gnt[g]    = gi;
        assign o_d_gnt[g]    = gd;
        assign o_i_rvalid[g] = rvi;
        assign o_d_rvalid[g] = rvd;
        assign o_i_rdata[g]  = rdi;
        assign o_d_rdata[g]  = rdd;
        assign o_mem_we[g]   = we;
        assign o_mem_addr[g] = ma;
        assign o_mem_din[g]  = md;
`ifdef ARB_STATS_EN
        assign o_st_i[g] = si;
        assign o_st_d[g] = sd;
        assign o_st_c[g] = sc;
`endif
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Reference model state, per instance (index 0 = round-robin, 1 = fixed priority)
    bit          last_d [2];
    bit          pend_i [2], pend_d [2], pend_dw [2];
    logic [31:0] exp_i [2], exp_d [2];
    logic [31:0] shadow [2][256];
    longint      st_i [2], st_d [2], st_c [2];
    bit          gi_last [2], gd_last [2];

    task automatic model_reset(input int m);
        last_d[m] = 1'b1;
        pend_i[m] = 1'b0; pend_d[m] = 1'b0; pend_dw[m] = 1'b0;
        st_i[m] = 0; st_d[m] = 0; st_c[m] = 0;
        for (int k = 0; k < 256; k++) shadow[m][k] = ram_init(k);
    endtask

    function automatic longint sat(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    task automatic check_cycle();
        for (int m = 0; m < 2; m++) begin
            bit ei, ed;
            string p;
            p  = $sformatf("m%0d", m);
            // Data wins unless round-robin gave data the previous turn while I also asks.
            ed = d_req[m] && !(i_req[m] && m == 0 && last_d[m]);
            ei = i_req[m] && !ed;
            chk({p, " i_gnt"}, o_i_gnt[m], ei);
            chk({p, " d_gnt"}, o_d_gnt[m], ed);
            chk({p, " mem_we"}, o_mem_we[m], ed && d_we[m]);
            chk({p, " mem_addr"}, o_mem_addr[m], ed ? d_addr[m] : i_addr[m]);
            chk({p, " mem_din"}, o_mem_din[m], d_wdata[m]);
            chk({p, " i_rvalid"}, o_i_rvalid[m], pend_i[m]);
            chk({p, " d_rvalid"}, o_d_rvalid[m], pend_d[m]);
            if (pend_i[m]) chk({p, " i_rdata"}, o_i_rdata[m], exp_i[m]);
            if (pend_d[m] && !pend_dw[m]) chk({p, " d_rdata"}, o_d_rdata[m], exp_d[m]);
`ifdef ARB_STATS_EN
            chk({p, " stat_i"}, o_st_i[m], st_i[m][31:0]);
            chk({p, " stat_d"}, o_st_d[m], st_d[m][31:0]);
            chk({p, " stat_c"}, o_st_c[m], st_c[m][31:0]);
`endif
            if (rst) begin
                model_reset(m);
            end else begin
                pend_i[m]  = ei;
                pend_d[m]  = ed;
                pend_dw[m] = ed && d_we[m];
                if (ei) exp_i[m] = shadow[m][i_addr[m][9:2]];
                if (ed) begin
                    exp_d[m] = shadow[m][d_addr[m][9:2]];
                    if (d_we[m]) shadow[m][d_addr[m][9:2]] = d_wdata[m];
                end
                if (ei || ed) last_d[m] = ed;
                if (ei) st_i[m] = sat(st_i[m]);
                if (ed) st_d[m] = sat(st_d[m]);
                if (i_req[m] && d_req[m]) st_c[m] = sat(st_c[m]);
            end
            gi_last[m] = ei;
            gd_last[m] = ed;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                          input logic [31:0] da, input logic [31:0] dw);
        for (int m = 0; m < 2; m++) begin
            i_req[m] = ir; i_addr[m] = ia;
            d_req[m] = dr; d_we[m] = dwe; d_addr[m] = da; d_wdata[m] = dw;
        end
    endtask

    task automatic rand_in(input int m);
        if (!(i_req[m] && !gi_last[m] && $urandom_range(7) != 0)) begin
            i_req[m]  = 1'($urandom_range(1));
            i_addr[m] = 32'($urandom_range(63)) << 2;
        end
        if (!(d_req[m] && !gd_last[m] && $urandom_range(7) != 0)) begin
            d_req[m]   = 1'($urandom_range(1));
            d_we[m]    = 1'($urandom_range(1));
            d_addr[m]  = 32'($urandom_range(63)) << 2;
            d_wdata[m] = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset(0);
        model_reset(1);
        repeat (3) step();
        rst = 1'b0;

        // Reset asserted with an instruction read in flight: its response must vanish.
        set_in(1, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        check_cycle();
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;

        // Instruction-only stream of three consecutive words
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'(k * 4), 0, 0, 0, 0);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0);
        step();

        // Data write then read-back of the same word
        set_in(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
        step();
        set_in(0, 0, 1, 0, 32'h10, 32'h0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        step();

        // Sustained conflict for four cycles
        set_in(1, 32'h20, 1, 0, 32'h30, 32'h0);
        repeat (4) step();
        set_in(0, 0, 0, 0, 0, 0);
        step();

        // Conflict for three cycles, then the data port backs off
        set_in(1, 32'h24, 1, 0, 32'h34, 32'h0);
        repeat (3) step();
        set_in(1, 32'h24, 0, 0, 32'h0, 32'h0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        step();

        for (int c = 0; c < 800; c++) begin
            rand_in(0);
            rand_in(1);
            step();
        end

        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
